// File: rtl/i2c_cmd_sequencer_if.sv
// Table and I2C-core handshake bundle between the command sequencer, its ROM and
// i2c_master_logic.
interface i2c_cmd_sequencer_if #(
    parameter int IDX_W = 3
);
    logic [IDX_W-1:0] cmd_idx;
    logic [31:0]      cmd_word;
    logic [7:0]       i2c_config;
    logic [6:0]       i2c_dev_addr;
    logic [7:0]       i2c_reg_addr;
    logic [7:0]       i2c_reg_data;
    logic             i2c_start;
    logic             i2c_done;
    logic             i2c_nack;
    logic [7:0]       i2c_rd_data;

    modport master (
        output cmd_idx, i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, i2c_start,
        input  cmd_word, i2c_done, i2c_nack, i2c_rd_data
    );

    modport slave (
        input  cmd_idx, i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, i2c_start,
        output cmd_word, i2c_done, i2c_nack, i2c_rd_data
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Walks a command table and drives each entry through the I2C master core with
// retry/timeout, post-write settle, read-back capture/compare and error reporting.
module i2c_cmd_sequencer #(
    parameter int NUM_CMDS    = 8,
    parameter int IDX_W       = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 24000,
    parameter int WR_DLY_CYC  = 60000
) (
    input  logic             clk_12m,
    input  logic             rst_n,
    input  logic             seq_start,
    input  logic             seq_abort,
    i2c_cmd_sequencer_if.master bus,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_idx,
    output logic             busy,
    output logic             seq_done,
    output logic             seq_err,
    output logic [IDX_W-1:0] err_idx,
    output logic [3:0]       state_debug
);
    localparam int CNT_MAX = (TIMEOUT_CYC > WR_DLY_CYC) ? TIMEOUT_CYC : WR_DLY_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_ISSUE  = 4'd3,
        S_WAIT   = 4'd4,
        S_CHECK  = 4'd5,
        S_SETTLE = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [3:0]       mode_q;
    logic             verify_q;
    logic             done_q;
    logic             nack_q;
    logic [7:0]       rdb_q;

    logic [3:0] w_mode;
    logic       is_rd, is_wr, att_fail, last_cmd, can_retry, tmo_hit, dly_hit;
    logic       unused_rsvd;

    assign w_mode      = bus.cmd_word[31:28];
    assign unused_rsvd = ^bus.cmd_word[26:23];
    assign is_rd       = (mode_q == 4'h4) || (mode_q == 4'h6);
    assign is_wr       = (mode_q == 4'h1) || (mode_q == 4'h2) || (mode_q == 4'h3);
    // A timed-out attempt (no done captured) counts as a failure like a NACK.
    assign att_fail    = !done_q || nack_q || (is_rd && verify_q && (rdb_q != bus.i2c_reg_data));
    assign last_cmd    = (bus.cmd_idx == IDX_W'(NUM_CMDS - 1));
    assign can_retry   = (retry_cnt < RTY_W'(MAX_RETRY));
    assign tmo_hit     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign dly_hit     = (cnt == CNT_W'(WR_DLY_CYC - 1));
    assign state_debug = state;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            retry_cnt        <= '0;
            mode_q           <= '0;
            verify_q         <= 1'b0;
            done_q           <= 1'b0;
            nack_q           <= 1'b0;
            rdb_q            <= '0;
            bus.cmd_idx      <= '0;
            bus.i2c_config   <= '0;
            bus.i2c_dev_addr <= '0;
            bus.i2c_reg_addr <= '0;
            bus.i2c_reg_data <= '0;
            bus.i2c_start    <= 1'b0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
            rd_idx           <= '0;
            busy             <= 1'b0;
            seq_done         <= 1'b0;
            seq_err          <= 1'b0;
            err_idx          <= '0;
        end else begin
            bus.i2c_start <= 1'b0;
            rd_valid      <= 1'b0;
            seq_done      <= 1'b0;
            if (seq_abort) begin
                state          <= S_IDLE;
                bus.i2c_config <= '0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (seq_start) begin
                        state       <= S_FETCH;
                        bus.cmd_idx <= '0;
                        retry_cnt   <= '0;
                        seq_err     <= 1'b0;
                        busy        <= 1'b1;
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        if (w_mode == 4'h0) begin
                            state          <= S_DONE;
                            seq_done       <= 1'b1;
                            busy           <= 1'b0;
                            bus.i2c_config <= '0;
                        end else begin
                            mode_q           <= w_mode;
                            verify_q         <= bus.cmd_word[27];
                            bus.i2c_config   <= {4'h0, w_mode};
                            bus.i2c_dev_addr <= bus.cmd_word[22:16];
                            bus.i2c_reg_addr <= bus.cmd_word[15:8];
                            bus.i2c_reg_data <= bus.cmd_word[7:0];
                            bus.i2c_start    <= 1'b1;
                            state            <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        cnt    <= '0;
                        done_q <= 1'b0;
                        state  <= S_WAIT;
                    end
                    S_WAIT: begin
                        // done is tested first so it wins over a coincident timeout
                        if (bus.i2c_done) begin
                            done_q <= 1'b1;
                            nack_q <= bus.i2c_nack;
                            rdb_q  <= bus.i2c_rd_data;
                            state  <= S_CHECK;
                        end else if (tmo_hit) begin
                            done_q <= 1'b0;
                            state  <= S_CHECK;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (done_q && is_rd) begin
                            rd_data  <= rdb_q;
                            rd_idx   <= bus.cmd_idx;
                            rd_valid <= 1'b1;
                        end
                        if (att_fail) begin
                            if (can_retry) begin
                                retry_cnt     <= retry_cnt + RTY_W'(1);
                                bus.i2c_start <= 1'b1;
                                state         <= S_ISSUE;
                            end else begin
                                state          <= S_ERR;
                                seq_err        <= 1'b1;
                                err_idx        <= bus.cmd_idx;
                                busy           <= 1'b0;
                                bus.i2c_config <= '0;
                            end
                        end else if (is_wr) begin
                            state          <= S_SETTLE;
                            cnt            <= '0;
                            bus.i2c_config <= '0;
                        end else if (last_cmd) begin
                            state          <= S_DONE;
                            seq_done       <= 1'b1;
                            busy           <= 1'b0;
                            bus.i2c_config <= '0;
                        end else begin
                            bus.cmd_idx <= bus.cmd_idx + IDX_W'(1);
                            retry_cnt   <= '0;
                            state       <= S_FETCH;
                        end
                    end
                    S_SETTLE: begin
                        if (!dly_hit) begin
                            cnt <= cnt + CNT_W'(1);
                        end else if (last_cmd) begin
                            state          <= S_DONE;
                            seq_done       <= 1'b1;
                            busy           <= 1'b0;
                            bus.i2c_config <= '0;
                        end else begin
                            bus.cmd_idx <= bus.cmd_idx + IDX_W'(1);
                            retry_cnt   <= '0;
                            state       <= S_FETCH;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    S_ERR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: ROM + I2C core model, a table-level expectation
// model and a per-cycle monitor.
module tb_i2c_cmd_sequencer;
    localparam int NC  = 8;
    localparam int IW  = 3;
    localparam int MR  = 3;
    localparam int TMO = 20;
    localparam int WRD = 30;

    logic clk_12m = 1'b0;
    logic rst_n, seq_start, seq_abort;
    logic [7:0] rd_data;
    logic rd_valid, busy, seq_done, seq_err;
    logic [IW-1:0] rd_idx, err_idx;
    logic [3:0] state_debug;

    i2c_cmd_sequencer_if #(.IDX_W(IW)) bus ();

    i2c_cmd_sequencer #(.NUM_CMDS(NC), .IDX_W(IW), .MAX_RETRY(MR),
                        .TIMEOUT_CYC(TMO), .WR_DLY_CYC(WRD)) dut (
        .clk_12m(clk_12m), .rst_n(rst_n), .seq_start(seq_start), .seq_abort(seq_abort),
        .bus(bus), .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx), .busy(busy),
        .seq_done(seq_done), .seq_err(seq_err), .err_idx(err_idx), .state_debug(state_debug)
    );

    always #5 clk_12m = ~clk_12m;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Synchronous command ROM: data follows the address by one cycle.
    logic [31:0] rom [NC];
    always @(posedge clk_12m) bus.cmd_word <= rom[bus.cmd_idx];

    function automatic logic [31:0] mk(input logic [3:0] m, input logic v, input logic [6:0] dev,
                                       input logic [7:0] rg, input logic [7:0] d);
        return {m, v, 4'h0, dev, rg, d};
    endfunction

    // I2C core model: done k cycles after the start cycle; first nack_n attempts NACK,
    // first silent_n attempts never answer.
    int core_k = 2, core_nack_n = 0, core_silent_n = 0, att_n = 0;
    logic [7:0] core_rdv = 8'h00;
    initial begin
        bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0; bus.i2c_rd_data = 8'h00;
        forever begin
            @(negedge clk_12m);
            if (rst_n && bus.i2c_start) begin
                int a;
                a = att_n;
                att_n++;
                if (a >= core_silent_n) begin
                    repeat (core_k) @(negedge clk_12m);
                    bus.i2c_done = 1'b1;
                    bus.i2c_nack = (a < core_nack_n);
                    bus.i2c_rd_data = core_rdv;
                    @(negedge clk_12m);
                    bus.i2c_done = 1'b0;
                    bus.i2c_nack = 1'b0;
                end
            end
        end
    end

    typedef struct { int idx; int gmin; int gmax; } st_t;
    typedef struct { int idx; logic [7:0] d; } rd_t;
    st_t exp_st[$];
    rd_t exp_rd[$];
    int exp_done, exp_err, exp_err_idx, done_cnt, n_starts;
    int starts_at[NC];

    // Table-level model: which attempts happen, what they return, how the run ends.
    task automatic build_model();
        int g, kind;
        exp_st.delete(); exp_rd.delete();
        exp_done = 0; exp_err = 0; exp_err_idx = 0;
        g = 0; kind = 3;
        for (int i = 0; i < NC; i++) begin
            logic [3:0] m;
            logic pass, rdm, fl;
            m = rom[i][31:28];
            if (m == 4'h0) begin exp_done = 1; return; end
            pass = 1'b0;
            for (int a = 0; a <= MR && !pass; a++) begin
                st_t s;
                s.idx = i;
                case (kind)
                    0: begin s.gmin = core_k + 1; s.gmax = core_k + 8; end
                    1: begin s.gmin = WRD + 1;    s.gmax = WRD + core_k + 8; end
                    2: begin s.gmin = TMO + 1;    s.gmax = TMO + 4; end
                    default: begin s.gmin = 0; s.gmax = 1000000; end
                endcase
                exp_st.push_back(s);
                if (g < core_silent_n) begin
                    kind = 2;
                end else begin
                    rdm = (m == 4'h4) || (m == 4'h6);
                    if (rdm) exp_rd.push_back('{i, core_rdv});
                    fl = (g < core_nack_n) || (rdm && rom[i][27] && core_rdv != rom[i][7:0]);
                    kind = 0;
                    if (!fl) begin
                        pass = 1'b1;
                        if (m >= 4'h1 && m <= 4'h3) kind = 1;
                    end
                end
                g++;
            end
            if (!pass) begin exp_err = 1; exp_err_idx = i; return; end
        end
        exp_done = 1;
    endtask

    task automatic prep();
        att_n = 0; done_cnt = 0; n_starts = 0;
        for (int i = 0; i < NC; i++) starts_at[i] = 0;
        build_model();
    endtask

    // Monitor: compares every start, read capture and completion pulse against the model.
    int cyc = 0, last_start = 0;
    logic p_start = 1'b0, p_rdv = 1'b0, p_done = 1'b0;
    always @(negedge clk_12m) begin
        cyc++;
        if (rst_n) begin
            chk("config_idle", busy ? 64'h0 : 64'(bus.i2c_config), 64'h0);
            if (bus.i2c_start && p_start) chk("start_width", 1, 0);
            if (rd_valid && p_rdv) chk("rd_valid_width", 1, 0);
            if (seq_done && p_done) chk("seq_done_width", 1, 0);
            if (bus.i2c_start) begin
                n_starts++;
                if (int'(bus.cmd_idx) < NC) starts_at[bus.cmd_idx]++;
                if (exp_st.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    st_t s;
                    int gap;
                    logic [31:0] w;
                    s = exp_st.pop_front();
                    w = rom[s.idx];
                    gap = cyc - last_start;
                    chk("start_idx", 64'(bus.cmd_idx), 64'(s.idx));
                    chk("start_cfg", {bus.i2c_config, 1'b0, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data},
                        {4'h0, w[31:28], 1'b0, w[22:16], w[15:8], w[7:0]});
                    checks++;
                    if (gap < s.gmin || gap > s.gmax) begin
                        failures++;
                        $display("FAIL start_gap act=%0d exp=[%0d,%0d]", gap, s.gmin, s.gmax);
                    end
                end
                last_start = cyc;
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
                else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    chk("rd_capture", {rd_idx, rd_data}, {IW'(r.idx), r.d});
                end
            end
            if (seq_done) done_cnt++;
        end
        p_start = bus.i2c_start; p_rdv = rd_valid; p_done = seq_done;
    end

    task automatic run_seq(input int bound, input int poke);
        int c;
        seq_start = 1'b1;
        @(negedge clk_12m);
        seq_start = 1'b0;
        c = 0;
        while (busy && c < bound) begin
            seq_start = (c == poke);
            @(negedge clk_12m);
            c++;
        end
        seq_start = 1'b0;
        if (c >= bound) chk("seq_timeout", 1, 0);
        repeat (3) @(negedge clk_12m);
    endtask

    task automatic finish_test(input string tag);
        chk({tag, "_starts_left"}, 64'(exp_st.size()), 0);
        chk({tag, "_rd_left"}, 64'(exp_rd.size()), 0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, "_seq_err"}, 64'(seq_err), 64'(exp_err));
        if (exp_err != 0) chk({tag, "_err_idx"}, 64'(err_idx), 64'(exp_err_idx));
        chk({tag, "_busy"}, 64'(busy), 0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.cmd_idx, bus.i2c_config, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data,
                    bus.i2c_start, rd_data, rd_valid, rd_idx, busy, seq_done, seq_err, err_idx, state_debug});
    endfunction

    task automatic wait_state(input logic [3:0] s, input string name);
        int c;
        c = 0;
        while (state_debug != s && c < 200) begin @(negedge clk_12m); c++; end
        if (c >= 200) chk(name, 64'(state_debug), 64'(s));
    endtask

    initial begin
        rst_n = 1'b0; seq_start = 1'b0; seq_abort = 1'b0;
        for (int i = 0; i < NC; i++) rom[i] = 32'h0;
        repeat (2) @(negedge clk_12m);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_12m);

        // T1: write then verified read, everything ACKs
        rom[0] = mk(4'h1, 1'b0, 7'h50, 8'h00, 8'h11);
        rom[1] = mk(4'h4, 1'b1, 7'h50, 8'h00, 8'h11);
        core_k = 2; core_rdv = 8'h11; core_nack_n = 0; core_silent_n = 0;
        prep(); run_seq(500, -1); finish_test("t1");
        chk("t1_lit_starts", 64'(n_starts), 2);
        chk("t1_lit_rd", {rd_idx, rd_data}, {3'd1, 8'h11});
        chk("t1_lit_done", 64'({done_cnt[3:0], seq_err}), {4'd1, 1'b0});

        // T2: read-back mismatch on every attempt
        core_rdv = 8'h22;
        prep(); run_seq(500, -1); finish_test("t2");
        chk("t2_lit_starts_idx1", 64'(starts_at[1]), 4);
        chk("t2_lit_err", {seq_err, err_idx, rd_data}, {1'b1, 3'd1, 8'h22});

        // abort while idle leaves the error flag alone
        seq_abort = 1'b1; @(negedge clk_12m); seq_abort = 1'b0; @(negedge clk_12m);
        chk("abort_idle_keeps_err", {seq_err, err_idx}, {1'b1, 3'd1});

        // T3: two NACKs on cmd0, then success
        core_rdv = 8'h11; core_nack_n = 2;
        prep(); run_seq(500, -1); finish_test("t3");
        chk("t3_lit_starts_idx0", 64'(starts_at[0]), 3);
        chk("t3_lit_ok", {seq_err, done_cnt[3:0]}, {1'b0, 4'd1});

        // T4: core never answers -> timeouts on every attempt
        rom[1] = 32'h0;
        core_nack_n = 0; core_silent_n = 99;
        prep(); run_seq(500, -1); finish_test("t4");
        chk("t4_lit", {seq_err, err_idx, n_starts[3:0]}, {1'b1, 3'd0, 4'd4});

        // T4b: done in the very cycle the timeout expires is a pass
        rom[0] = mk(4'h4, 1'b1, 7'h50, 8'h01, 8'h5A);
        core_silent_n = 0; core_k = TMO; core_rdv = 8'h5A;
        prep(); run_seq(500, -1); finish_test("t4b");
        chk("t4b_lit", {seq_err, done_cnt[3:0], n_starts[3:0], rd_data}, {1'b0, 4'd1, 4'd1, 8'h5A});

        // T5: full table of eight commands, plus a seq_start while busy
        rom[0] = mk(4'h5, 1'b0, 7'h21, 8'h00, 8'h00);
        rom[1] = mk(4'h4, 1'b0, 7'h22, 8'h01, 8'h00);
        rom[2] = mk(4'h6, 1'b1, 7'h23, 8'h02, 8'h3C);
        rom[3] = mk(4'h2, 1'b0, 7'h24, 8'h03, 8'hA5);
        rom[4] = mk(4'h5, 1'b0, 7'h25, 8'h04, 8'h00);
        rom[5] = mk(4'h4, 1'b1, 7'h26, 8'h05, 8'h3C);
        rom[6] = mk(4'h3, 1'b0, 7'h27, 8'h06, 8'h5A);
        rom[7] = mk(4'h6, 1'b1, 7'h28, 8'h07, 8'h3C);
        core_k = 2; core_rdv = 8'h3C;
        prep(); run_seq(1000, 10); finish_test("t5");
        chk("t5_lit", {n_starts[7:0], rd_idx, done_cnt[3:0]}, {8'd8, 3'd7, 4'd1});

        // T6a: abort during WAIT; the late done must be ignored
        for (int i = 0; i < NC; i++) rom[i] = 32'h0;
        rom[0] = mk(4'h1, 1'b0, 7'h50, 8'h00, 8'h11);
        core_k = 10;
        prep(); exp_st.delete(); exp_rd.delete();
        exp_st.push_back('{0, 0, 1000000});
        seq_start = 1'b1; @(negedge clk_12m); seq_start = 1'b0;
        wait_state(4'd4, "t6_reach_wait");
        repeat (3) @(negedge clk_12m);
        seq_abort = 1'b1; @(negedge clk_12m); seq_abort = 1'b0;
        chk("t6_abort", {busy, bus.i2c_config, state_debug}, 0);
        repeat (15) @(negedge clk_12m);
        chk("t6_after_late_done", {busy, state_debug, done_cnt[3:0], seq_err}, 0);
        chk("t6_starts_left", 64'(exp_st.size()), 0);

        // T6b: reset in the middle of the settle delay
        core_k = 2;
        prep(); exp_st.delete(); exp_rd.delete();
        exp_st.push_back('{0, 0, 1000000});
        seq_start = 1'b1; @(negedge clk_12m); seq_start = 1'b0;
        wait_state(4'd6, "t6_reach_settle");
        repeat (5) @(negedge clk_12m);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", all_outs(), 0);
        @(negedge clk_12m);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_12m);
        chk("t6_idle_after_reset", {busy, state_debug, bus.i2c_config}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
